// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Purpose  : CDB front end. Each producer channel has a one-entry holding
//            buffer; one buffer wins each cycle and drives a registered
//            broadcast. The grant is round-robin by default; defining
//            CDB_FIXED_PRIO_EN makes it fixed priority (lowest index wins).
// Revision : 1.0  initial release
// ============================================================================
module cdb_arbiter #(
    parameter  int NCH = 4,
    parameter  int DW  = 32,
    parameter  int LW  = 4,
    localparam int GW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic [NCH-1:0]    require,
    input  logic [NCH*DW-1:0] dataIn,
    input  logic [NCH*LW-1:0] labelIn,
    output logic [NCH-1:0]    requireAC,
    output logic              BCEN,
    output logic [LW-1:0]     BClabel,
    output logic [DW-1:0]     BCdata,
    output logic [GW-1:0]     grantId,
    output logic              busy,
    output logic              dropErr
);

    logic [NCH-1:0] r_buf_v;
    logic [DW-1:0]  r_buf_data  [NCH];
    logic [LW-1:0]  r_buf_label [NCH];

    logic           r_bc_en;
    logic [LW-1:0]  r_bc_label;
    logic [DW-1:0]  r_bc_data;
    logic [GW-1:0]  r_gnt_id;
    logic           r_drop;

    logic [NCH-1:0] w_lbl_nz;
    logic [NCH-1:0] w_rot;
    logic [NCH-1:0] w_grant;
    logic [NCH-1:0] w_ac;
    logic [NCH-1:0] w_load;
    logic [GW-1:0]  w_off;
    logic [GW-1:0]  w_gnt_idx;
    logic           w_any;
    logic           w_drop;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_lbl
        assign w_lbl_nz[gi] = |labelIn[gi*LW +: LW];
    end

`ifdef CDB_FIXED_PRIO_EN
    assign w_rot     = r_buf_v;
    assign w_gnt_idx = w_off;
`else
    localparam logic [GW:0]   c_NCH_W = (GW+1)'(NCH);
    localparam logic [GW-1:0] c_LAST  = GW'(NCH - 1);

    logic [GW-1:0] r_ptr;
    logic [GW:0]   w_sum;
    logic [GW-1:0] w_ptr_nxt;

    // Rotate so that bit 0 corresponds to the pointer channel.
    assign w_rot     = (r_buf_v >> r_ptr) | (r_buf_v << (NCH - int'(r_ptr)));
    assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_gnt_idx = (w_sum >= c_NCH_W) ? GW'(w_sum - c_NCH_W) : GW'(w_sum);
    assign w_ptr_nxt = (w_gnt_idx == c_LAST) ? '0 : w_gnt_idx + 1'b1;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= w_ptr_nxt;
        end
    end
`endif

    always_comb begin
        w_off = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = GW'(k);
            end
        end
    end

    assign w_any   = |r_buf_v;
    assign w_grant = NCH'(w_any) << w_gnt_idx;
    // A granted buffer frees this edge, so it may reload in the same cycle.
    assign w_ac    = ~r_buf_v | w_grant;
    assign w_load  = require & w_ac & w_lbl_nz;
    assign w_drop  = |(require & w_ac & ~w_lbl_nz);

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_buf_v <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_buf_data[i]  <= '0;
                r_buf_label[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (w_load[i]) begin
                    r_buf_v[i]     <= 1'b1;
                    r_buf_data[i]  <= dataIn[i*DW +: DW];
                    r_buf_label[i] <= labelIn[i*LW +: LW];
                end else if (w_grant[i]) begin
                    r_buf_v[i]     <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_bc_en    <= 1'b0;
            r_bc_label <= '0;
            r_bc_data  <= '0;
            r_gnt_id   <= '0;
            r_drop     <= 1'b0;
        end else begin
            r_bc_en <= w_any;
            if (w_any) begin
                r_bc_label <= r_buf_label[w_gnt_idx];
                r_bc_data  <= r_buf_data[w_gnt_idx];
                r_gnt_id   <= w_gnt_idx;
            end
            if (w_drop) begin
                r_drop <= 1'b1;
            end
        end
    end

    assign requireAC = w_ac;
    assign BCEN      = r_bc_en;
    assign BClabel   = r_bc_label;
    assign BCdata    = r_bc_data;
    assign grantId   = r_gnt_id;
    assign busy      = w_any;
    assign dropErr   = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_arbiter
// Purpose  : Self-checking bench for cdb_arbiter: directed scenarios plus
//            randomized traffic against a cycle-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_cdb_arbiter;
    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int LW  = 4;
    localparam int GW  = 2;

    logic              clk = 1'b0;
    logic              nRST;
    logic [NCH-1:0]    require;
    logic [NCH*DW-1:0] dataIn;
    logic [NCH*LW-1:0] labelIn;
    logic [NCH-1:0]    requireAC;
    logic              BCEN;
    logic [LW-1:0]     BClabel;
    logic [DW-1:0]     BCdata;
    logic [GW-1:0]     grantId;
    logic              busy;
    logic              dropErr;

    int checks   = 0;
    int failures = 0;

    cdb_arbiter #(.NCH(NCH), .DW(DW), .LW(LW)) dut (
        .clk(clk), .nRST(nRST), .require(require), .dataIn(dataIn),
        .labelIn(labelIn), .requireAC(requireAC), .BCEN(BCEN),
        .BClabel(BClabel), .BCdata(BCdata), .grantId(grantId),
        .busy(busy), .dropErr(dropErr)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit            mv    [NCH];
    logic [LW-1:0] mlab  [NCH];
    logic [DW-1:0] mdat  [NCH];
    int            mptr;
    bit            m_bcen;
    logic [LW-1:0] m_bclabel;
    logic [DW-1:0] m_bcdata;
    int            m_gid;
    bit            m_drop;

    function automatic int model_grant();
        int g = -1;
        for (int k = 0; k < NCH; k++) begin
            int idx;
`ifdef CDB_FIXED_PRIO_EN
            idx = k;
`else
            idx = (mptr + k) % NCH;
`endif
            if (g < 0 && mv[idx]) g = idx;
        end
        return g;
    endfunction

    function automatic logic [NCH-1:0] model_ac();
        logic [NCH-1:0] r;
        int g = model_grant();
        for (int i = 0; i < NCH; i++) r[i] = !mv[i] || (g == i);
        return r;
    endfunction

    function automatic bit model_busy();
        bit b = 0;
        for (int i = 0; i < NCH; i++) b |= mv[i];
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            mv[i] = 0; mlab[i] = '0; mdat[i] = '0;
        end
        mptr = 0; m_bcen = 0; m_bclabel = '0; m_bcdata = '0; m_gid = 0; m_drop = 0;
    endtask

    // One clock edge: the model consumes the inputs present at the edge.
    task automatic step();
        int g;
        logic [NCH-1:0] ac;
        g  = model_grant();
        ac = model_ac();
        @(posedge clk);
        if (g >= 0) begin
            m_bcen = 1; m_bclabel = mlab[g]; m_bcdata = mdat[g]; m_gid = g;
            mptr = (g + 1) % NCH;
        end else begin
            m_bcen = 0;
        end
        for (int i = 0; i < NCH; i++) begin
            logic [LW-1:0] l = labelIn[i*LW +: LW];
            if (require[i] && ac[i] && l != 0) begin
                mv[i] = 1; mlab[i] = l; mdat[i] = dataIn[i*DW +: DW];
            end else begin
                if (require[i] && ac[i]) m_drop = 1;
                if (i == g) mv[i] = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        require = '0; dataIn = '0; labelIn = '0;
        @(negedge clk);
        nRST = 1'b0;
        model_reset();
        #2;
        @(negedge clk);
        nRST = 1'b1;
    endtask

    task automatic set_ch(input int ch, input logic [LW-1:0] lab, input logic [DW-1:0] dat);
        require[ch] = 1'b1;
        labelIn[ch*LW +: LW] = lab;
        dataIn[ch*DW +: DW]  = dat;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (BCEN !== 1'b0 || busy !== 1'b0 || requireAC !== 4'hF || dropErr !== 1'b0 || grantId !== '0) begin
            failures++;
            $display("FAIL reset_init: BCEN=%b busy=%b AC=%h drop=%b gid=%0d expected 0 0 f 0 0",
                     BCEN, busy, requireAC, dropErr, grantId);
        end
        // Fill buffers 0,1,3 and a dropped request, then reset mid-traffic.
        set_ch(0, 4'd9, 32'h11); set_ch(1, 4'd10, 32'h22); set_ch(3, 4'd11, 32'h33);
        step();
        require = '0;
        set_ch(2, 4'd0, 32'h0);
        step();
        require = '0;
        checks++;
        if (busy !== 1'b1 || dropErr !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre: busy=%b drop=%b expected 1 1", busy, dropErr);
        end
        #2 nRST = 1'b0;
        model_reset();
        #1;
        checks++;
        if (BCEN !== 1'b0 || busy !== 1'b0 || requireAC !== 4'hF || dropErr !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: BCEN=%b busy=%b AC=%h drop=%b expected 0 0 f 0",
                     BCEN, busy, requireAC, dropErr);
        end
        @(negedge clk);
        nRST = 1'b1;
        step();
        checks++;
        if (BCEN !== 1'b0) begin
            failures++;
            $display("FAIL reset_noreplay: BCEN=%b expected 0", BCEN);
        end
    endtask

    task automatic test_single();
        do_reset();
        set_ch(1, 4'd5, 32'h0000_0007);
        step();
        require = '0;
        checks++;
        if (BCEN !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_lat: BCEN=%b busy=%b expected 0 1", BCEN, busy);
        end
        step();
        checks++;
        if (BCEN !== 1'b1 || BClabel !== 4'd5 || BCdata !== 32'd7 || grantId !== 2'd1) begin
            failures++;
            $display("FAIL single_bc: en=%b lab=%0d data=%0h gid=%0d expected 1 5 7 1",
                     BCEN, BClabel, BCdata, grantId);
        end
        step();
        checks++;
        if (BCEN !== 1'b0 || busy !== 1'b0 || BClabel !== 4'd5) begin
            failures++;
            $display("FAIL single_end: en=%b busy=%b lab=%0d expected 0 0 5", BCEN, busy, BClabel);
        end
    endtask

    task automatic test_contention();
        int exp_gid [6] = '{0, 1, 2, 3, 0, 3};
        int exp_lab [6] = '{1, 2, 3, 4, 12, 13};
        do_reset();
        for (int c = 0; c < NCH; c++) set_ch(c, LW'(c + 1), DW'(32'hA0 + c));
        step();
        require = '0;
        for (int n = 0; n < 4; n++) begin
            step();
            if (n == 3) begin
                set_ch(3, 4'd13, 32'hD3); set_ch(0, 4'd12, 32'hD0);
            end
            checks++;
            if (BCEN !== 1'b1 || int'(grantId) != exp_gid[n] || int'(BClabel) != exp_lab[n]) begin
                failures++;
                $display("FAIL contention_%0d: en=%b gid=%0d lab=%0d expected 1 %0d %0d",
                         n, BCEN, grantId, BClabel, exp_gid[n], exp_lab[n]);
            end
        end
        step();
        require = '0;
        for (int n = 4; n < 6; n++) begin
            step();
            checks++;
            if (BCEN !== 1'b1 || int'(grantId) != exp_gid[n] || int'(BClabel) != exp_lab[n]) begin
                failures++;
                $display("FAIL contention_%0d: en=%b gid=%0d lab=%0d expected 1 %0d %0d",
                         n, BCEN, grantId, BClabel, exp_gid[n], exp_lab[n]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int got_lab [$];
        do_reset();
        for (int n = 0; n < 3; n++) begin
            set_ch(0, LW'(6 + n), DW'(100 + n));
            checks++;
            if (requireAC[0] !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ac_%0d: requireAC0=%b expected 1", n, requireAC[0]);
            end
            step();
            if (BCEN === 1'b1) got_lab.push_back(int'(BClabel));
        end
        require = '0;
        for (int n = 0; n < 3; n++) begin
            step();
            if (BCEN === 1'b1) got_lab.push_back(int'(BClabel));
        end
        checks++;
        if (got_lab.size() != 3 || got_lab[0] != 6 || got_lab[1] != 7 || got_lab[2] != 8) begin
            failures++;
            $display("FAIL b2b_order: got %0d broadcasts first=%0d expected 3 broadcasts 6,7,8",
                     got_lab.size(), (got_lab.size() > 0) ? got_lab[0] : -1);
        end
    endtask

    task automatic test_label_zero();
        do_reset();
        set_ch(2, 4'd0, 32'hDEAD);
        checks++;
        if (requireAC[2] !== 1'b1) begin
            failures++;
            $display("FAIL lbl0_ac: requireAC2=%b expected 1", requireAC[2]);
        end
        step();
        require = '0;
        for (int n = 0; n < 3; n++) begin
            step();
            checks++;
            if (dropErr !== 1'b1 || BCEN !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL lbl0_%0d: drop=%b en=%b busy=%b expected 1 0 0", n, dropErr, BCEN, busy);
            end
        end
    endtask

    task automatic test_fairness();
        int ch3_seen = 0;
        do_reset();
        set_ch(0, 4'd1, 32'h1); set_ch(3, 4'd14, 32'hE);
        step();
        require[3] = 1'b0;
        for (int n = 0; n < 6; n++) begin
            labelIn[0 +: LW] = LW'(1 + (n % 7));
            step();
            if (BCEN === 1'b1 && grantId === 2'd3 && ch3_seen == 0) ch3_seen = n + 1;
        end
        require = '0;
        checks++;
`ifdef CDB_FIXED_PRIO_EN
        if (ch3_seen != 0) begin
            failures++;
            $display("FAIL fairness_fixed: ch3 granted at cycle %0d expected never", ch3_seen);
        end
`else
        if (ch3_seen == 0 || ch3_seen > 2) begin
            failures++;
            $display("FAIL fairness_rr: ch3 granted at cycle %0d expected 1..2", ch3_seen);
        end
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < NCH; c++) begin
                require[c] = ($urandom_range(0, 99) < 45);
                labelIn[c*LW +: LW] = ($urandom_range(0, 15) == 0) ? '0 : LW'($urandom_range(1, 15));
                dataIn[c*DW +: DW]  = $urandom;
            end
            checks++;
            if (requireAC !== model_ac() || busy !== model_busy()) begin
                failures++;
                $display("FAIL rand_ac_%0d: AC=%h busy=%b expected %h %b", n, requireAC, busy, model_ac(), model_busy());
            end
            step();
            checks++;
            if (BCEN !== m_bcen || BClabel !== m_bclabel || BCdata !== m_bcdata ||
                int'(grantId) != m_gid || dropErr !== m_drop) begin
                failures++;
                $display("FAIL rand_bc_%0d: en=%b lab=%0d data=%h gid=%0d drop=%b expected %b %0d %h %0d %b",
                         n, BCEN, BClabel, BCdata, grantId, dropErr, m_bcen, m_bclabel, m_bcdata, m_gid, m_drop);
            end
        end
        require = '0;
    endtask

    initial begin
        nRST = 1'b0;
        require = '0; dataIn = '0; labelIn = '0;
        model_reset();
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_label_zero();
        test_fairness();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
